// File: rtl/play_time_cnt.sv
// play_time_cnt: mm:ss play-time counter in BCD.
// A prescaler turns PRESC clock cycles of play into one elapsed second.
// time_bcd advances 00:00..99:59 and then wraps. tick_1hz and wrap are
// registered one-cycle pulses. digit is a combinational nibble mux for a
// display scan stage.
// Optional build macro PLAY_TIME_BLANK_EN: when defined, the minutes-tens
// digit shows as 4'hF (blank) while it is zero. time_bcd is not affected.
module play_time_cnt #(
  parameter int PRESC = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        clr,
  input  logic [2:1]  sel,
  output logic [16:1] time_bcd,
  output logic [4:1]  digit,
  output logic        tick_1hz,
  output logic        wrap
);

  localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc;
  logic          terminal;
  logic [16:1]   next_time;
  logic          next_wrap;

  assign terminal = (presc == LAST);

  // BCD increment with carries between digits; >= keeps every nibble in range
  always_comb begin
    next_time = time_bcd;
    next_wrap = 1'b0;
    if (time_bcd[4:1] >= 4'd9) begin
      next_time[4:1] = 4'd0;
      if (time_bcd[8:5] >= 4'd5) begin
        next_time[8:5] = 4'd0;
        if (time_bcd[12:9] >= 4'd9) begin
          next_time[12:9] = 4'd0;
          if (time_bcd[16:13] >= 4'd9) begin
            next_time[16:13] = 4'd0;
            next_wrap        = 1'b1;
          end else begin
            next_time[16:13] = time_bcd[16:13] + 4'd1;
          end
        end else begin
          next_time[12:9] = time_bcd[12:9] + 4'd1;
        end
      end else begin
        next_time[8:5] = time_bcd[8:5] + 4'd1;
      end
    end else begin
      next_time[4:1] = time_bcd[4:1] + 4'd1;
    end
  end

  // Prescaler, time register and pulses. clr beats play, and a paused
  // cycle holds the prescaler so no partial second is lost or added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      time_bcd <= '0;
      tick_1hz <= 1'b0;
      wrap     <= 1'b0;
    end else if (clr) begin
      presc    <= '0;
      time_bcd <= '0;
      tick_1hz <= 1'b0;
      wrap     <= 1'b0;
    end else if (play && terminal) begin
      presc    <= '0;
      time_bcd <= next_time;
      tick_1hz <= 1'b1;
      wrap     <= next_wrap;
    end else begin
      if (play) begin
        presc <= presc + 1'b1;
      end
      tick_1hz <= 1'b0;
      wrap     <= 1'b0;
    end
  end

  // Digit select for the display scan, with no added latency
  always_comb begin
    digit = 4'h0;
    case (sel)
      2'd0: digit = time_bcd[4:1];
      2'd1: digit = time_bcd[8:5];
      2'd2: digit = time_bcd[12:9];
      default: begin
`ifdef PLAY_TIME_BLANK_EN
        if (time_bcd[16:13] == 4'd0) begin
          digit = 4'hF;
        end else begin
          digit = time_bcd[16:13];
        end
`else
        digit = time_bcd[16:13];
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_play_time_cnt.sv
// Testbench for play_time_cnt, built with PRESC=4.
module tb_play_time_cnt;

  logic        clk;
  logic        rst_n;
  logic        play;
  logic        clr;
  logic [2:1]  sel;
  logic [16:1] time_bcd;
  logic [4:1]  digit;
  logic        tick_1hz;
  logic        wrap;

  int n_total;
  int n_pass;
  logic mon_en;
  logic prev_tick;
  logic prev_wrap;

  play_time_cnt #(.PRESC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play     (play),
    .clr      (clr),
    .sel      (sel),
    .time_bcd (time_bcd),
    .digit    (digit),
    .tick_1hz (tick_1hz),
    .wrap     (wrap)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cycles;
    logic        play;
    logic        clr;
    logic [15:0] exp_time;
    logic        exp_tick;
    logic        exp_wrap;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] exp_digit;
  } dvec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // advance n rising edges; return 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [15:0] t,
                             input logic tk, input logic wr);
    check({name, ".time"}, 16'(time_bcd), t);
    check({name, ".tick"}, 16'(tick_1hz), 16'(tk));
    check({name, ".wrap"}, 16'(wrap), 16'(wr));
  endtask

  // range and pulse-shape monitor
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      n_total++;
      if ((time_bcd[4:1] > 4'd9) || (time_bcd[8:5] > 4'd5) ||
          (time_bcd[12:9] > 4'd9) || (time_bcd[16:13] > 4'd9) ||
          (tick_1hz && prev_tick) || (wrap && prev_wrap) || (wrap && !tick_1hz))
        $display("FAIL monitor: time %h tick %b wrap %b prev_tick %b prev_wrap %b",
                 time_bcd, tick_1hz, wrap, prev_tick, prev_wrap);
      else
        n_pass++;
      prev_tick = tick_1hz;
      prev_wrap = wrap;
    end
  end

  vec_t  vecs[];
  dvec_t dvecs[4];
  logic [3:0] exp_d3;

  initial begin
    n_total = 0;
    n_pass = 0;
    mon_en = 1'b0;
    prev_tick = 1'b0;
    prev_wrap = 1'b0;
    rst_n = 1'b0;
    play = 1'b0;
    clr = 1'b0;
    sel = 2'd0;

    vecs = '{
      // first second from reset
      '{3,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{1,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b0},
      // clear while paused, then pause/resume mid-second
      '{1,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{2,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{1,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b0},
      // to 00:07, then clr on the terminal prescaler cycle
      '{1,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{28, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b0},
      '{3,  1'b1, 1'b0, 16'h0007, 1'b0, 1'b0},
      '{1,  1'b1, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0},
      // seconds-units carry
      '{1,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{40, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0},
      // to 00:42 and hold
      '{1,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{168, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0},
      '{1,  1'b0, 1'b0, 16'h0042, 1'b0, 1'b0}
    };

`ifdef PLAY_TIME_BLANK_EN
    exp_d3 = 4'hF;
`else
    exp_d3 = 4'h0;
`endif
    dvecs[0] = '{2'd0, 4'd2};
    dvecs[1] = '{2'd1, 4'd4};
    dvecs[2] = '{2'd2, 4'd0};
    dvecs[3] = '{2'd3, exp_d3};

    // reset state
    step(2);
    check_state("reset", 16'h0000, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset.digit%0d", s), 16'(digit), 16'h0);
    end
    sel = 2'd0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      play = vecs[i].play;
      clr = vecs[i].clr;
      step(vecs[i].cycles);
      check_state($sformatf("vec%0d", i), vecs[i].exp_time,
                  vecs[i].exp_tick, vecs[i].exp_wrap);
    end
    clr = 1'b0;
    play = 1'b0;

    // digit sweep at 00:42
    for (int i = 0; i < 4; i++) begin
      sel = dvecs[i].sel;
      #1;
      check($sformatf("digit_sel%0d", i), 16'(digit), 16'(dvecs[i].exp_digit));
    end

    // reset mid-second discards the partial second
    play = 1'b1;
    step(2);
    check_state("pre_rst", 16'h0042, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check_state("post_rst3", 16'h0000, 1'b0, 1'b0);
    step(1);
    check_state("post_rst4", 16'h0001, 1'b1, 1'b0);

    // 09:59 -> 10:00
    play = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    play = 1'b1;
    step(599 * 4);
    check_state("to_0959", 16'h0959, 1'b1, 1'b0);
    step(4);
    check_state("to_1000", 16'h1000, 1'b1, 1'b0);
    play = 1'b0;
    sel = 2'd3;
    #1;
    check("digit_1000_sel3", 16'(digit), 16'h1);

    // 99:59 -> 00:00 with wrap
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    play = 1'b1;
    step(5999 * 4);
    check_state("to_9959", 16'h9959, 1'b1, 1'b0);
    step(4);
    check_state("wrap", 16'h0000, 1'b1, 1'b1);
    step(1);
    check_state("after_wrap", 16'h0000, 1'b0, 1'b0);
    play = 1'b0;
    step(2);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
